// File: rtl/aud_write_sched.sv
// POKEY audio register write scheduler: CPU port plus sequencer FIFO, round-robin
// arbitrated, writes paced on the enp/enn grid. Define AUD_ZERO_CROSS_EN for AUDC click gating.
module aud_write_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enp,
    input  logic             enn,
    input  logic             cpu_req,
    input  logic [3:0]       cpu_addr,
    input  logic [7:0]       cpu_data,
    output logic             cpu_ack,
    input  logic             seq_valid,
    input  logic [3:0]       seq_addr,
    input  logic [7:0]       seq_data,
    output logic             seq_ready,
    output logic [7:0]       D,
    output logic             Addr0w,
    output logic             Addr2w,
    output logic             Addr4w,
    output logic             Addr6w,
    output logic             Addr8w,
    output logic             Addr9w,
    output logic [3:0]       AUDC,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level
`ifdef AUD_ZERO_CROSS_EN
    ,
    input  logic [3:0]       AUD1,
    input  logic [3:0]       AUD2,
    input  logic [3:0]       AUD3,
    input  logic [3:0]       AUD4
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [11:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [3:0]       addr_reg;
    logic [7:0]       d_reg;
    logic [9:0]       strobe_reg;
    logic [9:0]       dec;
    logic             cpu_ack_reg;
    logic             prefer_cpu_reg;
    logic             enp_q;
    logic             fifo_empty, fifo_pend, zc_ok;
    logic             push, pop;
    logic             grant_cpu, grant_fifo, set_strobe, clr_strobe, clr_d;
    logic [11:0]      head;

    // A coincident enp is dropped so enn always takes precedence.
    assign enp_q      = enp & ~enn;
    assign fifo_empty = (level_reg == '0);
    assign seq_ready  = (level_reg != LVL_W'(FIFO_DEPTH));
    assign push       = seq_valid & seq_ready;
    assign pop        = grant_fifo;
    assign head       = fifo_mem[rd_ptr_reg];
    assign fifo_pend  = ~fifo_empty & zc_ok;

`ifdef AUD_ZERO_CROSS_EN
    logic       head_is_audc;
    logic [3:0] aud_sel;
    logic [7:0] wait_cnt_reg;

    assign head_is_audc = head[8] & ~head[11];

    always_comb begin
        aud_sel = AUD1;
        case (head[10:9])
            2'd0: aud_sel = AUD1;
            2'd1: aud_sel = AUD2;
            2'd2: aud_sel = AUD3;
            2'd3: aud_sel = AUD4;
            default: aud_sel = AUD1;
        endcase
    end

    // Hold an AUDCn head until its channel output is at zero, or 255 enp waits pass.
    assign zc_ok = ~head_is_audc | (aud_sel == 4'd0) | (wait_cnt_reg == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (fifo_empty || grant_fifo) begin
            wait_cnt_reg <= '0;
        end else if (enp_q && !zc_ok) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
    end
`else
    assign zc_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_cpu  = 1'b0;
        grant_fifo = 1'b0;
        set_strobe = 1'b0;
        clr_strobe = 1'b0;
        clr_d      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enn && (cpu_req || fifo_pend)) begin
                    if (cpu_req && (!fifo_pend || prefer_cpu_reg)) begin
                        grant_cpu = 1'b1;
                    end else begin
                        grant_fifo = 1'b1;
                    end
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (enp_q) begin
                    set_strobe = 1'b1;
                    state_next = STROBE;
                end
            end
            STROBE: begin
                if (enp_q) begin
                    clr_strobe = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (enn) begin
                    clr_d      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_dec
            assign dec[gi] = (addr_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg       <= '0;
            d_reg          <= '0;
            strobe_reg     <= '0;
            cpu_ack_reg    <= 1'b0;
            prefer_cpu_reg <= 1'b1;
        end else begin
            cpu_ack_reg <= grant_cpu;
            if (grant_cpu) begin
                addr_reg       <= cpu_addr;
                d_reg          <= cpu_data;
                prefer_cpu_reg <= 1'b0;
            end else if (grant_fifo) begin
                addr_reg       <= head[11:8];
                d_reg          <= head[7:0];
                prefer_cpu_reg <= 1'b1;
            end
            if (set_strobe) strobe_reg <= dec;
            if (clr_strobe) strobe_reg <= '0;
            if (clr_d)      d_reg      <= '0;
        end
    end

    // Storage has no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= {seq_addr, seq_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign cpu_ack    = cpu_ack_reg;
    assign D          = d_reg;
    assign Addr0w     = strobe_reg[0];
    assign Addr2w     = strobe_reg[2];
    assign Addr4w     = strobe_reg[4];
    assign Addr6w     = strobe_reg[6];
    assign Addr8w     = strobe_reg[8];
    assign Addr9w     = strobe_reg[9];
    assign AUDC       = {strobe_reg[7], strobe_reg[5], strobe_reg[3], strobe_reg[1]};
    assign busy       = (state_reg != IDLE);
    assign fifo_level = level_reg;

endmodule

// File: tb/tb_aud_write_sched.sv
// Directed bench for aud_write_sched; slow-clock grid is 8 clk per period, enn at phase 0, enp at phase 4.
`timescale 1ns/1ps
module tb_aud_write_sched;

    logic       clk = 1'b0;
    logic       reset, enp, enn, cpu_req, cpu_ack, seq_valid, seq_ready, busy;
    logic [3:0] cpu_addr, seq_addr, AUDC;
    logic [7:0] cpu_data, seq_data, D;
    logic       Addr0w, Addr2w, Addr4w, Addr6w, Addr8w, Addr9w;
    logic [2:0] fifo_level;
`ifdef AUD_ZERO_CROSS_EN
    logic [3:0] AUD1, AUD2, AUD3, AUD4;
`endif

    int checks = 0;
    int errors = 0;
    int phase;

    aud_write_sched dut (
        .clk(clk), .reset(reset), .enp(enp), .enn(enn),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .seq_valid(seq_valid), .seq_addr(seq_addr), .seq_data(seq_data), .seq_ready(seq_ready),
        .D(D), .Addr0w(Addr0w), .Addr2w(Addr2w), .Addr4w(Addr4w), .Addr6w(Addr6w),
        .Addr8w(Addr8w), .Addr9w(Addr9w), .AUDC(AUDC), .busy(busy), .fifo_level(fifo_level)
`ifdef AUD_ZERO_CROSS_EN
        , .AUD1(AUD1), .AUD2(AUD2), .AUD3(AUD3), .AUD4(AUD4)
`endif
    );

    always #5 clk = ~clk;

    // Enable grid, updated 2 ns after each rising edge so #1 samples see the values the DUT used.
    initial begin
        phase = 0;
        enn   = 1'b0;
        enp   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            phase = (phase + 1) % 8;
            enn   = (phase == 0);
            enp   = (phase == 4);
        end
    end

    function automatic logic [9:0] strobes();
        return {Addr9w, Addr8w, AUDC[3], Addr6w, AUDC[2], Addr4w, AUDC[1], Addr2w, AUDC[0], Addr0w};
    endfunction

    function automatic logic [9:0] exp_vec(input logic [3:0] a);
        logic [9:0] v;
        v = '0;
        if (a < 4'd10) v = 10'b1 << a;
        return v;
    endfunction

    logic [9:0] mon_prev = '0;
    always @(posedge clk) begin
        #1;
        if (strobes() != 10'd0 && mon_prev == 10'd0)
            $display("WRITE t=%0t strobes=%b D=%h", $time, strobes(), D);
        mon_prev = strobes();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (cpu_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (strobes() != 10'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_enn(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (enn) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (D !== 8'h00) begin errors++; $display("FAIL reset_D got %h want 00", D); end
        checks++;
        if (strobes() !== 10'd0) begin errors++; $display("FAIL reset_strobes got %b want 0", strobes()); end
        checks++;
        if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ack_busy got ack=%b busy=%b want 0 0", cpu_ack, busy);
        end
        checks++;
        if (fifo_level !== 3'd0 || seq_ready !== 1'b1) begin
            errors++; $display("FAIL reset_fifo got level=%0d ready=%b want 0 1", fifo_level, seq_ready);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_writes();
        logic [3:0] addrs [4] = '{4'd0, 4'd12, 4'd9, 4'd8};
        logic [7:0] datas [4] = '{8'h1F, 8'h77, 8'h3C, 8'h81};
        bit ok;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = addrs[i];
            cpu_data = datas[i];
            cpu_req  = 1'b1;
            wait_ack(ok);
            cpu_req = 1'b0;
            checks++;
            if (!ok) begin
                errors++; $display("FAIL cpu_ack_timeout addr=%0d got no ack want ack", addrs[i]);
                continue;
            end
            checks++;
            if (enn !== 1'b1 || D !== datas[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL cpu_grant addr=%0d got enn=%b D=%h busy=%b want enn=1 D=%h busy=1",
                         addrs[i], enn, D, busy, datas[i]);
            end
            for (int t = 1; t <= 20; t++) begin
                logic [9:0] es;
                logic [7:0] ed;
                tick();
                es = (t >= 4 && t < 12) ? exp_vec(addrs[i]) : 10'd0;
                ed = (t < 16) ? datas[i] : 8'h00;
                checks++;
                if (strobes() !== es || D !== ed || busy !== (t < 16) || cpu_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL cpu_seq addr=%0d t=%0d got str=%b D=%h busy=%b ack=%b want str=%b D=%h busy=%b ack=0",
                             addrs[i], t, strobes(), D, busy, cpu_ack, es, ed, (t < 16));
                end
            end
        end
    endtask

    task automatic test_fifo_order();
        logic [3:0] addrs [4] = '{4'd1, 4'd3, 4'd5, 4'd7};
        logic [7:0] datas [4] = '{8'hC3, 8'hE2, 8'h61, 8'hEF};
        bit ok;
        wait_enn(ok);
        for (int i = 0; i < 4; i++) begin
            seq_valid = 1'b1;
            seq_addr  = addrs[i];
            seq_data  = datas[i];
            tick();
        end
        checks++;
        if (fifo_level !== 3'd4 || seq_ready !== 1'b0) begin
            errors++; $display("FAIL fifo_full got level=%0d ready=%b want 4 0", fifo_level, seq_ready);
        end
        seq_addr = 4'd0;
        seq_data = 8'hFF;
        tick();
        seq_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4) begin
            errors++; $display("FAIL fifo_overflow got level=%0d want 4", fifo_level);
        end
        for (int i = 0; i < 4; i++) begin
            wait_strobe(ok);
            checks++;
            if (!ok || strobes() !== exp_vec(addrs[i]) || D !== datas[i] || fifo_level !== 3'(3 - i)) begin
                errors++;
                $display("FAIL fifo_order i=%0d got str=%b D=%h level=%0d want str=%b D=%h level=%0d",
                         i, strobes(), D, fifo_level, exp_vec(addrs[i]), datas[i], 3 - i);
            end
            for (int n = 0; n < 20 && strobes() != 10'd0; n++) tick();
        end
        repeat (40) tick();
        checks++;
        if (busy !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL fifo_drain got busy=%b level=%0d want 0 0", busy, fifo_level);
        end
    endtask

    task automatic test_round_robin();
        int   g = 0;
        int   cpu_t [2] = '{0, 0};
        logic prev = 1'b0;
        logic exp_cpu;
        reset = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
        cpu_addr  = 4'd2;
        cpu_data  = 8'hA5;
        cpu_req   = 1'b1;
        seq_valid = 1'b1;
        seq_addr  = 4'd4;
        seq_data  = 8'h5A;
        for (int n = 0; n < 200 && g < 4; n++) begin
            tick();
            if (busy && !prev) begin
                exp_cpu = (g % 2 == 0);
                checks++;
                if (cpu_ack !== exp_cpu || D !== (exp_cpu ? 8'hA5 : 8'h5A)) begin
                    errors++;
                    $display("FAIL rr_grant g=%0d got cpu=%b D=%h want cpu=%b D=%h",
                             g, cpu_ack, D, exp_cpu, exp_cpu ? 8'hA5 : 8'h5A);
                end
                if (cpu_ack && g % 2 == 0) cpu_t[g / 2] = n;
                g++;
            end
            prev = busy;
        end
        checks++;
        if (g != 4) begin errors++; $display("FAIL rr_count got %0d grants want 4", g); end
        checks++;
        if (cpu_t[1] - cpu_t[0] != 48) begin
            errors++; $display("FAIL rr_ack_spacing got %0d clk want 48", cpu_t[1] - cpu_t[0]);
        end
        cpu_req   = 1'b0;
        seq_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        bit   ok;
        int   extra = 0;
        logic prev;
        cpu_addr = 4'd6;
        cpu_data = 8'h44;
        cpu_req  = 1'b1;
        wait_ack(ok);
        cpu_req   = 1'b0;
        seq_valid = 1'b1;
        seq_addr  = 4'd1;
        seq_data  = 8'h22;
        tick();
        seq_addr = 4'd3;
        seq_data = 8'h33;
        tick();
        seq_valid = 1'b0;
        wait_strobe(ok);
        checks++;
        if (!ok || Addr6w !== 1'b1 || fifo_level !== 3'd2) begin
            errors++; $display("FAIL mid_pre got Addr6w=%b level=%0d want 1 2", Addr6w, fifo_level);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (strobes() !== 10'd0 || D !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset got str=%b D=%h busy=%b want 0 00 0", strobes(), D, busy);
        end
        checks++;
        if (fifo_level !== 3'd0 || seq_ready !== 1'b1) begin
            errors++; $display("FAIL mid_fifo got level=%0d ready=%b want 0 1", fifo_level, seq_ready);
        end
        reset    = 1'b0;
        cpu_addr = 4'd3;
        cpu_data = 8'h99;
        cpu_req  = 1'b1;
        wait_ack(ok);
        cpu_req = 1'b0;
        checks++;
        if (!ok || D !== 8'h99) begin errors++; $display("FAIL mid_next_grant got ack=%b D=%h want 1 99", ok, D); end
        wait_strobe(ok);
        checks++;
        if (!ok || strobes() !== exp_vec(4'd3)) begin
            errors++; $display("FAIL mid_next_strobe got %b want %b", strobes(), exp_vec(4'd3));
        end
        prev = busy;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (busy && !prev) extra++;
            prev = busy;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL mid_stale_writes got %0d want 0", extra); end
    endtask

`ifdef AUD_ZERO_CROSS_EN
    task automatic test_zero_cross();
        bit ok;
        int n;
        int enps = 0;
        AUD4 = 4'hF;
        wait_enn(ok);
        seq_valid = 1'b1;
        seq_addr  = 4'd7;
        seq_data  = 8'h5E;
        tick();
        seq_valid = 1'b0;
        repeat (40) tick();
        checks++;
        if (busy !== 1'b0 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL zc_hold got busy=%b level=%0d want 0 1", busy, fifo_level);
        end
        wait_enn(ok);
        AUD4 = 4'h0;
        for (n = 1; n <= 20; n++) begin
            tick();
            if (busy) break;
        end
        checks++;
        if (n != 8 || D !== 8'h5E) begin
            errors++; $display("FAIL zc_release got grant_at=%0d D=%h want 8 5E", n, D);
        end
        for (int k = 0; k < 40 && busy; k++) tick();
        AUD4 = 4'hF;
        wait_enn(ok);
        seq_valid = 1'b1;
        seq_addr  = 4'd7;
        seq_data  = 8'h6D;
        tick();
        seq_valid = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (busy) break;
            if (enp) enps++;
        end
        checks++;
        if (busy !== 1'b1 || enps != 255 || D !== 8'h6D) begin
            errors++; $display("FAIL zc_timeout got busy=%b enps=%0d D=%h want 1 255 6D", busy, enps, D);
        end
        for (int k = 0; k < 40 && busy; k++) tick();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = 4'd0;
        cpu_data  = 8'h00;
        seq_valid = 1'b0;
        seq_addr  = 4'd0;
        seq_data  = 8'h00;
`ifdef AUD_ZERO_CROSS_EN
        AUD1 = 4'h0;
        AUD2 = 4'h0;
        AUD3 = 4'h0;
        AUD4 = 4'h0;
`endif
        test_reset();
        test_cpu_writes();
        test_fifo_order();
        test_round_robin();
        test_reset_mid_write();
`ifdef AUD_ZERO_CROSS_EN
        test_zero_cross();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
